program_loader: RTL and testbench

Upstream feeder for the instruction regfile. Accepts a program as a valid/ready stream of 16-bit instruction words and writes them into consecutive regfile slots starting at a chosen origin, wrapping modulo 32. While a load is in progress it asserts hold, which the top level uses to gate the program counter's pc_en so the state machine does not execute a partially written program.

---
 rtl/program_loader.sv | 121 ++++++++++++
 tb/tb_program_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Streams instruction words into consecutive regfile slots (wrapping modulo 2**ADDR_W)
// and holds the program counter off while a load is in flight.
module program_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] origin,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              hold,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  count
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] origin_q;
  logic [LEN_W-1:0]  length_q;
  logic [LEN_W-1:0]  count_q;
  logic              error_q;

  logic              len_ok_p0;
  logic              accept_p0;
  logic              take_p0;
  logic              last_p0;

  logic              wr_en_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic [ADDR_W-1:0] wr_addr_p1;

  // Accept stage: handshake qualified by abort so an aborted beat never reaches the regfile
  always_comb begin
    len_ok_p0 = (length != '0) && (length <= MAX_LEN);
    accept_p0 = in_valid && (state == LOAD);
    take_p0   = accept_p0 && !abort;
    last_p0   = (count_q == (length_q - LEN_W'(1)));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start && len_ok_p0) next_state = LOAD;
      end
      LOAD: begin
        if (abort)                  next_state = IDLE;
        else if (take_p0 && last_p0) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      origin_q <= '0;
      length_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        if (len_ok_p0) begin
          origin_q <= origin;
          length_q <= length;
          count_q  <= '0;
          error_q  <= 1'b0;
        end else begin
          error_q  <= 1'b1;
        end
      end
      if (state == LOAD && abort) error_q <= 1'b1;
      if (take_p0) count_q <= count_q + LEN_W'(1);
    end
  end

  // Write stage: one cycle after acceptance, address uses the pre-increment count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_p1   <= 1'b0;
      wr_data_p1 <= '0;
      wr_addr_p1 <= '0;
    end else begin
      wr_en_p1 <= take_p0;
      if (take_p0) begin
        wr_data_p1 <= in_data;
        wr_addr_p1 <= origin_q + count_q[ADDR_W-1:0];
      end
    end
  end

  assign in_ready = (state == LOAD);
  assign hold     = (state != IDLE);
  assign done     = (state == DONE);
  assign error    = error_q;
  assign count    = count_q;
  assign wr_en    = wr_en_p1;
  assign wr_data  = wr_data_p1;
  assign wr_addr  = wr_addr_p1;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios with random data/stalls against a
// beat-level reference model of which slots receive which words.
module tb_program_loader;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 6;
  localparam int SLOTS  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] origin;
  logic [LEN_W-1:0]  length;
  logic              abort;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              hold;
  logic              done;
  logic              error;
  logic [LEN_W-1:0]  count;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [SLOTS];
  int                hits [SLOTS];
  int                writes_total = 0;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .origin(origin), .length(length),
    .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en), .hold(hold),
    .done(done), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  // Behavioural regfile plus per-slot write tally
  initial for (int i = 0; i < SLOTS; i++) hits[i] = 0;
  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr]  <= wr_data;
      hits[wr_addr] <= hits[wr_addr] + 1;
      writes_total  <= writes_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load from the bench's point of view: the model is "every accepted beat i lands
  // at (o+i) mod 32 one cycle later; the L-th beat coincides with done".
  task automatic do_load(input int o, input int L, input int abort_beat,
                         input bit stall, input bit fixed, input bit mid_start);
    logic [DATA_W-1:0] dq[$];
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] pd;
    logic [ADDR_W-1:0] pa;
    bit pend, aborted, v;
    int n, cyc, base_writes;
    int base_hits [SLOTS];
    pend = 0; aborted = 0; n = 0; cyc = 0; pd = '0; pa = '0;
    base_writes = writes_total;
    for (int i = 0; i < SLOTS; i++) base_hits[i] = hits[i];

    chk("idle_hold", hold, 0);
    chk("idle_ready", in_ready, 0);
    origin = ADDR_W'(o);
    length = LEN_W'(L);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    origin = ADDR_W'($urandom);
    length = LEN_W'($urandom);

    while (n < L && cyc < 400) begin
      chk("load_hold", hold, 1);
      chk("load_ready", in_ready, 1);
      chk("load_done", done, 0);
      chk("load_error", error, 0);
      chk("load_count", count, n);
      chk("load_wr_en", wr_en, pend);
      if (pend) begin
        chk("load_wr_addr", wr_addr, pa);
        chk("load_wr_data", wr_data, pd);
      end
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      d = fixed ? DATA_W'(16'hA001 + n) : DATA_W'($urandom);
      in_valid = v;
      in_data  = d;
      abort    = (abort_beat > 0) && v && (n + 1 == abort_beat);
      start    = mid_start && (cyc == 5);
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      if (abort) begin
        abort   = 1'b0;
        aborted = 1;
        break;
      end
      pend = v;
      if (v) begin
        pa = ADDR_W'(o + n);
        pd = d;
        dq.push_back(d);
        n++;
      end
      cyc++;
    end
    chk("load_cycle_budget", (cyc < 400), 1);

    if (aborted) begin
      chk("abort_hold", hold, 0);
      chk("abort_ready", in_ready, 0);
      chk("abort_error", error, 1);
      chk("abort_done", done, 0);
      chk("abort_wr_en", wr_en, 0);
      chk("abort_count", count, n);
      tick();
      chk("abort_after_done", done, 0);
      chk("abort_after_wr_en", wr_en, 0);
    end else begin
      chk("done_wr_en", wr_en, 1);
      chk("done_wr_addr", wr_addr, pa);
      chk("done_wr_data", wr_data, pd);
      chk("done_pulse", done, 1);
      chk("done_hold", hold, 1);
      chk("done_ready", in_ready, 0);
      chk("done_count", count, L);
      abort = 1'($urandom_range(0, 1));
      tick();
      abort = 1'b0;
      chk("post_hold", hold, 0);
      chk("post_done", done, 0);
      chk("post_wr_en", wr_en, 0);
      chk("post_count", count, L);
      chk("post_error", error, 0);
    end

    chk("write_total", writes_total - base_writes, dq.size());
    for (int i = 0; i < dq.size(); i++)
      chk("regfile_word", mem[(o + i) % SLOTS], dq[i]);
    for (int a = 0; a < SLOTS; a++) begin
      int exp_hits;
      exp_hits = 0;
      for (int i = 0; i < dq.size(); i++)
        if ((o + i) % SLOTS == a) exp_hits++;
      chk("slot_hits", hits[a] - base_hits[a], exp_hits);
    end
  endtask

  initial begin
    int base;
    int o, L, ab;
    rst = 1'b0; start = 1'b0; origin = '0; length = '0; abort = 1'b0;
    in_data = '0; in_valid = 1'b0;
    #12;
    chk("rst_hold", hold, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_count", count, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    tick();
    rst = 1'b1;
    tick();

    // Reset in the middle of a load
    origin = 5'd0; length = 6'd8; start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DATA_W'($urandom);
      tick();
    end
    chk("midrst_count_before", count, 3);
    #3 rst = 1'b0;
    #1;
    chk("midrst_hold", hold, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_count", count, 0);
    base = writes_total;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_idle_hold", hold, 0);
      chk("midrst_idle_wr_en", wr_en, 0);
    end
    chk("midrst_no_writes", writes_total - base, 0);
    in_valid = 1'b0;

    // Basic load
    do_load(4, 3, 0, 1'b0, 1'b1, 1'b0);
    chk("basic_read_slot5", mem[5], 16'hA002);

    // Wrap with stalls
    do_load(30, 4, 0, 1'b1, 1'b0, 1'b0);

    // Bad lengths
    length = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_error", error, 1);
    chk("len0_hold", hold, 0);
    chk("len0_ready", in_ready, 0);
    chk("len0_wr_en", wr_en, 0);
    chk("len0_count", count, 4);
    length = 6'd33; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len33_error", error, 1);
    chk("len33_hold", hold, 0);
    do_load($urandom_range(0, 31), 1, 0, 1'b0, 1'b0, 1'b0);
    length = LEN_W'($urandom_range(33, 63)); start = 1'b1;
    tick();
    start = 1'b0;
    chk("lenbig_error", error, 1);
    chk("lenbig_hold", hold, 0);
    chk("lenbig_count", count, 1);
    tick();
    chk("lenbig_wr_en", wr_en, 0);

    // Abort on the third accepted beat
    do_load(9, 6, 3, 1'b0, 1'b0, 1'b0);

    // Abort while idle changes nothing
    do_load(12, 2, 0, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_error", error, 0);
    chk("idle_abort_hold", hold, 0);

    // Full program with a start pulse mid-load
    do_load(7, 32, 0, 1'b1, 1'b0, 1'b1);

    // Randomised loads
    for (int k = 0; k < 8; k++) begin
      o  = $urandom_range(0, 31);
      L  = $urandom_range(1, 32);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, L) : 0;
      do_load(o, L, ab, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
